// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad front end.
// Key codes are {row, col}; frame bit index equals the key code.
package keypad_pkg;

    typedef logic [3:0]  key_code_t;
    typedef logic [15:0] frame_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam key_code_t KEY_SUBMIT_LETTER = 4'd12;
    localparam key_code_t KEY_SUBMIT_WORD   = 4'd14;

    function automatic key_code_t key_code(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return {row, col};
    endfunction

    function automatic logic is_one_hot(input frame_t f);
        return (f != '0) && ((f & (f - 16'd1)) == '0);
    endfunction

    function automatic key_code_t frame_index(input frame_t f);
        key_code_t idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (f[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_frame_debouncer.sv
// Accepts a matrix frame only after it repeats for DEBOUNCE_SCANS
// consecutive frame closes; deb_update pulses with each acceptance.
module frame_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  frame_t frame,
    input  logic   frame_done,
    output frame_t debounced,
    output logic   deb_update
);

    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    frame_t          prev_q, prev_d;
    frame_t          deb_q, deb_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic            upd_q, upd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            deb_q    <= '0;
            stable_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            stable_q <= stable_d;
            upd_q    <= upd_d;
        end
    end

    always_comb begin
        prev_d   = prev_q;
        deb_d    = deb_q;
        stable_d = stable_q;
        upd_d    = 1'b0;
        if (frame_done) begin
            if (frame == prev_q) begin
                stable_d = (stable_q == STABLE_MAX)
                         ? stable_q
                         : stable_q + SW'(1);
            end else begin
                stable_d = '0;
            end
            prev_d = frame;
            if (stable_d == STABLE_MAX) begin
                deb_d = frame;
                upd_d = 1'b1;
            end
        end
    end

    assign debounced  = deb_q;
    assign deb_update = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scans the 4x4 keypad, debounces whole-matrix frames and
// emits one key event per fresh single-key press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam int CW = $clog2(SCAN_CYCLES);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_CYCLES - 1);

    logic [CW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    frame_t        frame_q, frame_d;
    logic          sample;
    logic          frame_done;

    frame_t        debounced;
    logic          deb_update;

    key_code_t     key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          multi_key_q, multi_key_d;
    logic          zero_seen_q, zero_seen_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q     <= '0;
            col_idx_q   <= '0;
            frame_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
            zero_seen_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            frame_q     <= frame_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_key_q <= multi_key_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    always_comb begin
        sample     = (dwell_q == DWELL_LAST);
        frame_done = sample && (col_idx_q == 2'd3);
        dwell_d    = sample ? '0 : dwell_q + CW'(1);
        col_idx_d  = sample ? col_idx_q + 2'd1 : col_idx_q;
        frame_d    = frame_q;
        if (sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                frame_d[keypad_pkg::key_code(2'(r), col_idx_q)] = row_in[3-r];
            end
        end
    end

    // The debouncer sees frame_d so the C3 bits land in the closing frame.
    frame_debouncer #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame_d),
        .frame_done (frame_done),
        .debounced  (debounced),
        .deb_update (deb_update)
    );

    // zero_seen_q clears on reset so a key held across reset stays silent.
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        multi_key_d = multi_key_q;
        zero_seen_d = zero_seen_q;
        if (deb_update) begin
            zero_seen_d = (debounced == '0);
            unique case (1'b1)
                (debounced == '0): begin
                    key_held_d  = 1'b0;
                    multi_key_d = 1'b0;
                end
                is_one_hot(debounced): begin
                    key_held_d  = 1'b1;
                    multi_key_d = 1'b0;
                    if (zero_seen_q) begin
                        key_valid_d = 1'b1;
                        key_code_d  = frame_index(debounced);
                    end
                end
                default: begin
                    key_held_d  = 1'b0;
                    multi_key_d = 1'b1;
                end
            endcase
        end
    end

    assign col_out   = 4'b1000 >> col_idx_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-gated matrix model
// and a queue of expected key events checked on every key_valid.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          vectors;
    int          miscompares;
    int          valid_cnt;

    keypad_scanner #(
        .SCAN_CYCLES   (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .multi_key(multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && col_out[3-c]) row_in[3-r] = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        return (sel == 0) ? key_held : multi_key;
    endfunction

    task automatic wait_on(input int sel, input logic val,
                           input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pick(sel) === val) break;
        end
        chk(tag, int'(pick(sel)), int'(val));
    endtask

    // Scoreboard: every key_valid must match the oldest expected code.
    always @(negedge clk) begin
        if (key_valid || multi_key) begin
            vectors++;
            assert (!(key_valid && multi_key)) else begin
                miscompares++;
                $error("FAIL excl: observed valid=%0b multi=%0b expected not both",
                       key_valid, multi_key);
            end
        end
        if (key_valid) begin
            valid_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_valid: observed code %0d expected no pulse",
                       key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                assert (key_code === e) else begin
                    miscompares++;
                    $error("FAIL key_code: observed %0d expected %0d", key_code, e);
                end
            end
        end
    end

    initial begin
        int base;
        logic seen_c3;
        vectors     = 0;
        miscompares = 0;
        valid_cnt   = 0;
        pressed     = '0;
        rst         = 1'b1;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_col", int'(col_out), 8);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_multi", int'(multi_key), 0);
        chk("rst_code", int'(key_code), 0);
        rst = 1'b0;
        chk("rot_c0", int'(col_out), 8);
        repeat (4) @(negedge clk);
        chk("rot_c1", int'(col_out), 4);
        repeat (4) @(negedge clk);
        chk("rot_c2", int'(col_out), 2);
        repeat (4) @(negedge clk);
        chk("rot_c3", int'(col_out), 1);
        repeat (4) @(negedge clk);
        chk("rot_wrap", int'(col_out), 8);
        repeat (40) @(negedge clk);

        // Clean press of R0C1
        exp_q.push_back(4'd1);
        pressed = 16'h0002;
        wait_on(0, 1'b1, 64, "press_held");
        repeat (40) @(negedge clk);
        chk("press_code", int'(key_code), 1);
        pressed = '0;
        wait_on(0, 1'b0, 64, "release_held");
        repeat (40) @(negedge clk);
        chk("press_q", exp_q.size(), 0);
        chk("press_cnt", valid_cnt, 1);

        // Bounce on R3C0, alternating per frame, then held
        seen_c3 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col_out == 4'b0001) seen_c3 = 1'b1;
            if (seen_c3 && col_out == 4'b1000) break;
        end
        chk("bounce_sync", int'(col_out), 8);
        base = valid_cnt;
        for (int f = 0; f < 4; f++) begin
            pressed = (f % 2 == 0) ? 16'h1000 : 16'h0000;
            repeat (16) @(negedge clk);
        end
        chk("bounce_quiet", valid_cnt, base);
        chk("bounce_held0", int'(key_held), 0);
        exp_q.push_back(4'd12);
        pressed = 16'h1000;
        wait_on(0, 1'b1, 64, "bounce_held");
        repeat (64) @(negedge clk);
        chk("bounce_one", valid_cnt, base + 1);
        pressed = '0;
        wait_on(0, 1'b0, 64, "bounce_rel");
        repeat (40) @(negedge clk);

        // R1C1 + R2C0 together, then drop R2C0
        base = valid_cnt;
        pressed = 16'h0120;
        wait_on(1, 1'b1, 64, "multi_on");
        chk("multi_held", int'(key_held), 0);
        pressed = 16'h0020;
        repeat (64) @(negedge clk);
        chk("multi_to_one_held", int'(key_held), 1);
        chk("multi_to_one_multi", int'(multi_key), 0);
        chk("multi_novalid", valid_cnt, base);
        pressed = '0;
        wait_on(0, 1'b0, 64, "multi_rel");
        repeat (40) @(negedge clk);

        // Repeat presses of R1C1
        base = valid_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'd5);
            pressed = 16'h0020;
            repeat (64) @(negedge clk);
            pressed = '0;
            repeat (48) @(negedge clk);
        end
        chk("repeat_cnt", valid_cnt, base + 3);
        chk("repeat_q", exp_q.size(), 0);

        // Reset while R2C0 held
        exp_q.push_back(4'd8);
        pressed = 16'h0100;
        wait_on(0, 1'b1, 64, "rkey_held");
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_held", int'(key_held), 0);
        chk("rmid_code", int'(key_code), 0);
        chk("rmid_col", int'(col_out), 8);
        rst = 1'b0;
        base = valid_cnt;
        repeat (96) @(negedge clk);
        chk("rpost_held", int'(key_held), 1);
        chk("rpost_novalid", valid_cnt, base);
        pressed = '0;
        wait_on(0, 1'b0, 64, "rpost_rel");
        repeat (32) @(negedge clk);
        exp_q.push_back(4'd8);
        pressed = 16'h0100;
        wait_on(0, 1'b1, 64, "rre_held");
        repeat (8) @(negedge clk);
        chk("rre_valid", valid_cnt, base + 1);
        pressed = '0;
        wait_on(0, 1'b0, 64, "rre_rel");
        repeat (16) @(negedge clk);

        chk("final_q", exp_q.size(), 0);
        chk("final_cnt", valid_cnt, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
